// File: rtl/ctrl_pkg.sv
// Shared controller definitions for the address-generator blocks:
// FSM state encoding and trip-count normalisation.
package ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // A zero trip count is treated as one iteration so that a level
    // never free-runs through its whole counter range.
    function automatic logic [31:0] norm_bound(input logic [31:0] b);
        return (b == 32'd0) ? 32'd1 : b;
    endfunction

endpackage

// File: rtl/nested_loop_counter_loop_level.sv
// One level of the loop nest: counts 0..bound-1, advancing on carry_in.
// Ports: clk, rst (async high), clear (sync), bound (normalised, >=1),
//   carry_in, count, at_final (count==bound-1), carry_out (wrapping now).
module loop_level #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] bound,
    input  logic             carry_in,
    output logic [WIDTH-1:0] count,
    output logic             at_final,
    output logic             carry_out
);

    assign at_final  = (count == bound - WIDTH'(1));
    assign carry_out = carry_in & at_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (carry_in)
            count <= at_final ? '0 : count + WIDTH'(1);
    end

endmodule

// File: rtl/nested_loop_counter.sv
// Chained loop counters (level 0 innermost) running one pass per start.
// Ports: clk, rst (async high), clear, start, en, bounds[L*W] in;
//   counts[L*W], wrap[L] (pulse), last (comb), busy, done (pulse) out.
module nested_loop_counter
    import ctrl_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int WIDTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        start,
    input  logic                        en,
    input  logic [NUM_LEVELS*WIDTH-1:0] bounds,
    output logic [NUM_LEVELS*WIDTH-1:0] counts,
    output logic [NUM_LEVELS-1:0]       wrap,
    output logic                        last,
    output logic                        busy,
    output logic                        done
);

    ctrl_state_t                 state;
    logic [NUM_LEVELS*WIDTH-1:0] bnd_q;
    logic [NUM_LEVELS*WIDTH-1:0] bnd_norm;
    logic [NUM_LEVELS-1:0]       at_final;
    logic [NUM_LEVELS-1:0]       cin;
    logic [NUM_LEVELS-1:0]       cout;
    logic                        adv;

    assign adv  = (state == RUN) & en & ~clear;
    assign last = (state == RUN) & (&at_final);
    assign busy = (state == RUN);

    always_comb begin
        bnd_norm = '0;
        for (int i = 0; i < NUM_LEVELS; i++)
            bnd_norm[i*WIDTH +: WIDTH] =
                WIDTH'(norm_bound(32'(bounds[i*WIDTH +: WIDTH])));
    end

    for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_lvl
        if (i == 0) begin : g_first
            assign cin[i] = adv;
        end else begin : g_chain
            assign cin[i] = cout[i-1];
        end

        loop_level #(.WIDTH(WIDTH)) u_lvl (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .bound     (bnd_q[i*WIDTH +: WIDTH]),
            .carry_in  (cin[i]),
            .count     (counts[i*WIDTH +: WIDTH]),
            .at_final  (at_final[i]),
            .carry_out (cout[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bnd_q <= '0;
            wrap  <= '0;
            done  <= 1'b0;
        end else begin
            // wrap/done describe the step taken on this edge, so they
            // are qualified by the same advance term as the counters.
            wrap <= cout;
            done <= adv & last;
            if (clear) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state <= RUN;
                            bnd_q <= bnd_norm;
                        end
                    end
                    RUN: begin
                        if (en && last)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
